wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Shares the single commit-side write port (ROB update / CDB) among the three functional units: ALU, LSU and MUL.
//  Each unit's writeback {valid, rob tag, value} goes into its own small FIFO.
//  The FIFO heads are arbitrated round-robin into one registered CDB output with a valid/ready handshake.
//  Sits between the arith/lsu/mul writeback ports and the reorder buffer update port.
// PARAMETERS
//  DATA_W      32  writeback value width
//  TAG_W       5   ROB index width
//  FIFO_DEPTH  2   entries per source FIFO; power of two, >=2
// PORTS
//  clk_i            in   1       clock
//  reset_i          in   1       asynchronous, active-low reset
//  flush_i          in   1       synchronous clear of all queued writebacks
//  alu_wb_valid_i   in   1       ALU writeback valid
//  alu_wb_tag_i     in   TAG_W   ALU ROB index
//  alu_wb_data_i    in   DATA_W  ALU result
//  alu_wb_ready_o   out  1       ALU FIFO can accept
//  lsu_wb_* / mul_wb_*  same four ports as ALU, for LSU and MUL
//  cdb_valid_o      out  1       CDB entry valid
//  cdb_tag_o        out  TAG_W   ROB index of CDB entry
//  cdb_data_o       out  DATA_W  value of CDB entry
//  cdb_src_o        out  2       source of entry: 0=ALU, 1=LSU, 2=MUL
//  cdb_ready_i      in   1       ROB accepts CDB entry this cycle
//  err_overflow_o   out  1       sticky: a valid_i was dropped while ready_o=0
// BEHAVIOUR
//  - Reset (reset_i=0) values:
//    - All FIFOs empty; cdb_valid_o/tag/data/src = 0; err_overflow_o = 0.
//    - All *_wb_ready_o = 1.
//    - RR pointer = MUL, so ALU has first priority.
//  - Push: a source FIFO writes when valid_i & ready_o.
//    - ready_o = (count != FIFO_DEPTH), driven from registered count only; no comb path from cdb_ready_i.
//    - A full FIFO refuses a push even if it pops the same cycle.
//    - valid_i while ready_o=0: beat dropped, err_overflow_o <= 1.
//  - Output register: a slot is free when !cdb_valid_o, or cdb_valid_o & cdb_ready_i.
//    - If free and any FIFO head valid: winner's head loads into the output register, that FIFO pops, RR pointer <= winner.
//    - If free and no head valid: cdb_valid_o <= 0.
//  - Stall: while cdb_valid_o & !cdb_ready_i, the output holds stable and no FIFO pops. Pushes still allowed.
//  - Round-robin search starts at (pointer+1) mod 3 in order ALU, LSU, MUL, wrapping MUL->ALU. The pointer moves only on a grant.
//  - Latency: a push accepted in cycle N appears as cdb_valid_o in cycle N+2 when uncontended. No same-cycle bypass.
//  - Per-source capacity in flight: FIFO_DEPTH plus at most one in the output register.
//  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap mod depth. count ranges 0..FIFO_DEPTH.
//    Simultaneous push and pop on a non-full FIFO keeps count unchanged.
//  - flush_i: next edge clears FIFOs, cdb_valid_o, err_overflow_o and the RR pointer (back to MUL).
//    - Pushes in the flush cycle are discarded; flush wins over push, pop and grant.
//  - Async reset mid-transfer: all state returns to reset values immediately; the in-flight entry is lost.
//  - Tag and data are carried unmodified; width is exact, with no extension.
// CONFIGURATION
//  - WB_ARB_LSU_PRIO_EN defined: LSU head, when valid, always wins.
//    ALU and MUL round-robin among themselves when the LSU head is empty.
//    The pointer updates only on ALU/MUL grants.
//  - Undefined: pure 3-way round-robin as above.
// TESTING
//  - Reset: hold reset_i=0 -> cdb_valid_o=0, all *_wb_ready_o=1, err_overflow_o=0, cdb_src_o=0.
//  - Single ALU push in cycle N (tag=3, data=0x1234), cdb_ready_i=1
//    -> cycle N+2: cdb_valid_o=1, tag=3, data=0x1234, src=0, for exactly one cycle.
//  - ALU/LSU/MUL push together in cycle N (tags 1/2/3), cdb_ready_i=1
//    -> cycles N+2..N+4 give src 0,1,2.
//    -> with WB_ARB_LSU_PRIO_EN the order is 1,0,2.
//  - cdb_ready_i=0, ALU pushes tags 4,5,6 on consecutive cycles
//    -> tag 4 held on the CDB, alu_wb_ready_o=0 after tag 6.
//    -> a 4th push sets err_overflow_o=1.
//    -> raising cdb_ready_i drains 4,5,6 in order, and ready_o returns to 1.
//  - Two LSU entries queued and one on the CDB, flush_i pulsed in cycle N
//    -> cycle N+1: cdb_valid_o=0, lsu_wb_ready_o=1; no further CDB output.
//  - reset_i asserted while cdb_valid_o=1 (not at a clock edge)
//    -> cdb_valid_o=0 immediately; after release, a fresh ALU push completes at N+2.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-unit FIFOs for ALU/LSU/MUL, round-robin granted into one registered CDB slot.
// Optional WB_ARB_LSU_PRIO_EN: a valid LSU head always wins; ALU and MUL round-robin between themselves.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alu_wb_valid_i,
  input  logic [TAG_W-1:0]  alu_wb_tag_i,
  input  logic [DATA_W-1:0] alu_wb_data_i,
  output logic              alu_wb_ready_o,
  input  logic              lsu_wb_valid_i,
  input  logic [TAG_W-1:0]  lsu_wb_tag_i,
  input  logic [DATA_W-1:0] lsu_wb_data_i,
  output logic              lsu_wb_ready_o,
  input  logic              mul_wb_valid_i,
  input  logic [TAG_W-1:0]  mul_wb_tag_i,
  input  logic [DATA_W-1:0] mul_wb_data_i,
  output logic              mul_wb_ready_o,
  output logic              cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [1:0]        cdb_src_o,
  input  logic              cdb_ready_i,
  output logic              err_overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_LSU = 2'd1, SRC_MUL = 2'd2} src_e;

  logic [2:0]       wbValid, wbReady, push, pop, headValid;
  logic [ENT_W-1:0] wbEntry   [3];
  logic [ENT_W-1:0] headEntry [4];

  assign wbValid    = {mul_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};
  assign wbEntry[0] = {alu_wb_tag_i, alu_wb_data_i};
  assign wbEntry[1] = {lsu_wb_tag_i, lsu_wb_data_i};
  assign wbEntry[2] = {mul_wb_tag_i, mul_wb_data_i};
  assign headEntry[3] = '0;

  assign alu_wb_ready_o = wbReady[0];
  assign lsu_wb_ready_o = wbReady[1];
  assign mul_wb_ready_o = wbReady[2];

  logic             cdbValid_q, cdbValid_d;
  logic [TAG_W-1:0] cdbTag_q, cdbTag_d;
  logic [DATA_W-1:0] cdbData_q, cdbData_d;
  logic [1:0]       cdbSrc_q, cdbSrc_d;
  logic             errOvf_q, errOvf_d;
  src_e             rrPtr_q, rrPtr_d;

  logic [3:0] eligible;
  src_e       winner, o0, o1, o2;
  logic       anyElig, slotFree, grant;

  for (genvar g = 0; g < 3; g++) begin : gSrc
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Ready comes only from the registered count, so a full FIFO cannot take a beat even while popping.
    assign wbReady[g]   = (count_q != FULL_CNT);
    assign headValid[g] = (count_q != '0);
    assign headEntry[g] = mem_q[rdPtr_q];
    assign push[g]      = wbValid[g] & wbReady[g] & ~flush_i;
    assign pop[g]       = grant & (winner == 2'(g));

    always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (flush_i) begin
        wrPtr_d = '0;
        rdPtr_d = '0;
        count_d = '0;
      end else begin
        if (push[g]) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (pop[g])  rdPtr_d = rdPtr_q + PTR_W'(1);
        case ({push[g], pop[g]})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[g]) mem_q[wrPtr_q] <= wbEntry[g];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
      end
    end
  end

  assign slotFree = ~cdbValid_q | cdb_ready_i;
  assign grant    = slotFree & anyElig & ~flush_i;

  always_comb begin
    eligible = {1'b0, headValid};
`ifdef WB_ARB_LSU_PRIO_EN
    if (headValid[SRC_LSU]) eligible = 4'b0010;
`endif
    case (rrPtr_q)
      SRC_ALU: begin o0 = SRC_LSU; o1 = SRC_MUL; o2 = SRC_ALU; end
      SRC_LSU: begin o0 = SRC_MUL; o1 = SRC_ALU; o2 = SRC_LSU; end
      default: begin o0 = SRC_ALU; o1 = SRC_LSU; o2 = SRC_MUL; end
    endcase
    winner  = o0;
    anyElig = 1'b1;
    if (eligible[o0])      winner = o0;
    else if (eligible[o1]) winner = o1;
    else if (eligible[o2]) winner = o2;
    else                   anyElig = 1'b0;
  end

  always_comb begin
    cdbValid_d = cdbValid_q;
    cdbTag_d   = cdbTag_q;
    cdbData_d  = cdbData_q;
    cdbSrc_d   = cdbSrc_q;
    rrPtr_d    = rrPtr_q;
    errOvf_d   = errOvf_q | (|(wbValid & ~wbReady));
    if (flush_i) begin
      cdbValid_d = 1'b0;
      rrPtr_d    = SRC_MUL;
      errOvf_d   = 1'b0;
    end else if (slotFree) begin
      if (anyElig) begin
        cdbValid_d             = 1'b1;
        {cdbTag_d, cdbData_d}  = headEntry[winner];
        cdbSrc_d               = winner;
`ifdef WB_ARB_LSU_PRIO_EN
        if (winner != SRC_LSU) rrPtr_d = winner;
`else
        rrPtr_d = winner;
`endif
      end else begin
        cdbValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cdbValid_q <= 1'b0;
      cdbTag_q   <= '0;
      cdbData_q  <= '0;
      cdbSrc_q   <= '0;
      errOvf_q   <= 1'b0;
      rrPtr_q    <= SRC_MUL;
    end else begin
      cdbValid_q <= cdbValid_d;
      cdbTag_q   <= cdbTag_d;
      cdbData_q  <= cdbData_d;
      cdbSrc_q   <= cdbSrc_d;
      errOvf_q   <= errOvf_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign cdb_valid_o    = cdbValid_q;
  assign cdb_tag_o      = cdbTag_q;
  assign cdb_data_o     = cdbData_q;
  assign cdb_src_o      = cdbSrc_q;
  assign err_overflow_o = errOvf_q;

endmodule
